// File: rtl/comp_pkg.sv
// Shared types and constants for the compare-sweep controller.
package comp_pkg;

  localparam int CMP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/compdowncounter.sv
// Loadable down-counter holding the current sweep index.
module compdowncounter
  import comp_pkg::*;
#(
  parameter int W = CMP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_q;

  // Load wins over decrement; the controller never asks for both at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_val;
    end else if (dec) begin
      r_q <= r_q - ONE;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/comp_sweeper.sv
// Sweep controller: walks an index from start_idx down to 1, issuing one
// handshaked compare per index and counting how many compares swapped.
module comp_sweeper
  import comp_pkg::*;
#(
  parameter int W = CMP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] start_idx,
  input  logic         abort,
  output logic         cmp_valid,
  input  logic         cmp_ready,
  input  logic         cmp_swap,
  output logic [W-1:0] cmp_idx,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] swaps,
  output logic         tc
);

  localparam logic [W-1:0] IDX_ONE = W'(1);
  localparam logic [W-1:0] SAT_MAX = '1;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == SAT_MAX) ? v : v + IDX_ONE;
  endfunction

  sweep_state_t r_state;
  logic         r_cmp_valid;
  logic         r_busy;
  logic         r_done;
  logic [W-1:0] r_swaps;

  logic [W-1:0] w_cmp_idx;
  logic         w_hs;
  logic         w_last;
  logic         w_load;
  logic         w_dec;

  // r_cmp_valid is only ever set while in RUN, so it qualifies the handshake.
  assign w_hs   = r_cmp_valid & cmp_ready;
  assign w_last = (w_cmp_idx == IDX_ONE);
  assign w_load = (r_state == IDLE) & start & (start_idx != '0);
  assign w_dec  = (r_state == RUN) & w_hs & ~abort & ~w_last;

  compdowncounter #(
    .W (W)
  ) u_idx (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (start_idx),
    .dec      (w_dec),
    .q        (w_cmp_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cmp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_swaps     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_swaps <= '0;
            r_busy  <= 1'b1;
            if (start_idx != '0) begin
              r_state     <= RUN;
              r_cmp_valid <= 1'b1;
            end else begin
              // Empty sweep: report completion without issuing a compare.
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_hs && cmp_swap) begin
            r_swaps <= sat_inc(r_swaps);
          end
          if (abort || (w_hs && w_last)) begin
            r_state     <= DONE;
            r_cmp_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_cmp_valid <= 1'b0;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmp_valid = r_cmp_valid;
  assign cmp_idx   = w_cmp_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign swaps     = r_swaps;
  assign tc        = (w_cmp_idx <= IDX_ONE);

endmodule

// File: tb/tb_comp_sweeper.sv
// Scoreboard bench for comp_sweeper: expected compare indices are queued at
// start and popped on every observed handshake.
module tb_comp_sweeper;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] start_idx;
  logic         abort;
  logic         cmp_valid;
  logic         cmp_ready;
  logic         cmp_swap;
  logic [W-1:0] cmp_idx;
  logic         busy;
  logic         done;
  logic [W-1:0] swaps;
  logic         tc;

  int total = 0;
  int bad   = 0;
  int exp_idx_q[$];

  comp_sweeper #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_idx (start_idx),
    .abort     (abort),
    .cmp_valid (cmp_valid),
    .cmp_ready (cmp_ready),
    .cmp_swap  (cmp_swap),
    .cmp_idx   (cmp_idx),
    .busy      (busy),
    .done      (done),
    .swaps     (swaps),
    .tc        (tc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_idx = '0; abort = 1'b0;
    cmp_ready = 1'b0; cmp_swap = 1'b0;
    tick(); tick();
    total++; if (cmp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", cmp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (cmp_idx !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", cmp_idx); end
    total++; if (swaps !== 4'd0) begin bad++; $display("FAIL reset_swaps got=%0d want=0", swaps); end
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL reset_tc got=%b want=1", tc); end
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_full_sweep();
    int done_cyc = -1;
    int e;
    exp_idx_q.delete();
    for (int i = 15; i >= 1; i--) exp_idx_q.push_back(i);
    start = 1'b1; start_idx = 4'd15; cmp_ready = 1'b1; cmp_swap = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin done_cyc = c; break; end
      if (cmp_valid && cmp_ready) begin
        if (exp_idx_q.size() == 0) begin
          total++; bad++; $display("FAIL full_extra_hs got=%0d want=none", cmp_idx);
        end else begin
          e = exp_idx_q.pop_front();
          total++; if (cmp_idx !== W'(e)) begin bad++; $display("FAIL full_idx got=%0d want=%0d", cmp_idx, e); end
          total++; if (tc !== (e == 1)) begin bad++; $display("FAIL full_tc idx=%0d got=%b want=%b", e, tc, (e == 1)); end
        end
      end
      tick();
    end
    total++; if (done_cyc != 16) begin bad++; $display("FAIL full_done_cycle got=%0d want=16", done_cyc); end
    total++; if (exp_idx_q.size() != 0) begin bad++; $display("FAIL full_missing_hs got=%0d want=0", exp_idx_q.size()); end
    total++; if (swaps !== 4'd0) begin bad++; $display("FAIL full_swaps got=%0d want=0", swaps); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL full_done_pulse got=%b want=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_stall();
    int done_cyc = -1;
    int done_n = 0;
    int hs_n = 0;
    int e;
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_idx = '0;
    exp_idx_q.delete();
    for (int i = 4; i >= 1; i--) exp_idx_q.push_back(i);
    start = 1'b1; start_idx = 4'd4; cmp_ready = 1'b0; cmp_swap = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      cmp_ready = (c % 2 == 1);
      if (done) begin done_n++; if (done_cyc < 0) done_cyc = c; end
      if (prev_stall) begin
        total++; if (cmp_idx !== prev_idx || cmp_valid !== 1'b1) begin
          bad++; $display("FAIL stall_hold got=%0d/%b want=%0d/1", cmp_idx, cmp_valid, prev_idx);
        end
      end
      if (cmp_valid && cmp_ready) begin
        hs_n++;
        if (exp_idx_q.size() == 0) begin
          total++; bad++; $display("FAIL stall_extra_hs got=%0d want=none", cmp_idx);
        end else begin
          e = exp_idx_q.pop_front();
          total++; if (cmp_idx !== W'(e)) begin bad++; $display("FAIL stall_idx got=%0d want=%0d", cmp_idx, e); end
        end
      end
      prev_stall = cmp_valid && !cmp_ready;
      prev_idx = cmp_idx;
      tick();
    end
    total++; if (hs_n != 4) begin bad++; $display("FAIL stall_hs_count got=%0d want=4", hs_n); end
    total++; if (done_n != 1) begin bad++; $display("FAIL stall_done_count got=%0d want=1", done_n); end
    total++; if (done_cyc != 8) begin bad++; $display("FAIL stall_done_cycle got=%0d want=8", done_cyc); end
    cmp_ready = 1'b0;
  endtask

  task automatic test_saturate();
    int exp_sw = 0;
    logic seen_done = 1'b0;
    exp_idx_q.delete();
    for (int i = 15; i >= 1; i--) exp_idx_q.push_back(i);
    start = 1'b1; start_idx = 4'd15; cmp_ready = 1'b1; cmp_swap = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin seen_done = 1'b1; break; end
      total++; if (swaps !== W'(exp_sw)) begin bad++; $display("FAIL sat_running got=%0d want=%0d", swaps, exp_sw); end
      if (cmp_valid && cmp_ready) begin
        if (exp_idx_q.size() != 0) void'(exp_idx_q.pop_front());
        exp_sw = (exp_sw < 15) ? exp_sw + 1 : 15;
      end
      tick();
    end
    total++; if (seen_done !== 1'b1) begin bad++; $display("FAIL sat_timeout got=no_done want=done"); end
    total++; if (swaps !== 4'd15) begin bad++; $display("FAIL sat_final got=%0d want=15", swaps); end
    cmp_swap = 1'b0;
    tick(); tick();
    total++; if (swaps !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d want=15", swaps); end
  endtask

  task automatic test_abort();
    int e;
    logic hit = 1'b0;
    exp_idx_q.delete();
    for (int i = 8; i >= 5; i--) exp_idx_q.push_back(i);
    start = 1'b1; start_idx = 4'd8; cmp_ready = 1'b1; cmp_swap = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (cmp_valid && cmp_ready && exp_idx_q.size() != 0) begin
        e = exp_idx_q.pop_front();
        total++; if (cmp_idx !== W'(e)) begin bad++; $display("FAIL abort_idx got=%0d want=%0d", cmp_idx, e); end
      end
      if (cmp_idx == 4'd5 && cmp_valid) begin
        abort = 1'b1; cmp_swap = 1'b1; hit = 1'b1;
        tick();
        break;
      end
      tick();
    end
    abort = 1'b0; cmp_swap = 1'b0;
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL abort_reach got=no_idx5 want=idx5"); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_done got=%b want=1", done); end
    total++; if (cmp_idx !== 4'd5) begin bad++; $display("FAIL abort_idx_hold got=%0d want=5", cmp_idx); end
    total++; if (swaps !== 4'd1) begin bad++; $display("FAIL abort_swaps got=%0d want=1", swaps); end
    total++; if (cmp_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", cmp_valid); end
    tick();
    total++; if (busy !== 1'b0 || cmp_idx !== 4'd5) begin bad++; $display("FAIL abort_idle got=%b/%0d want=0/5", busy, cmp_idx); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || cmp_idx !== 4'd5) begin
      bad++; $display("FAIL abort_in_idle got=%b/%b/%0d want=0/0/5", busy, done, cmp_idx);
    end
  endtask

  task automatic test_zero_start();
    start = 1'b1; start_idx = 4'd0; cmp_ready = 1'b1;
    tick();
    total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL zero_done got=%b/%b want=1/1", done, busy); end
    total++; if (cmp_valid !== 1'b0) begin bad++; $display("FAIL zero_valid got=%b want=0", cmp_valid); end
    total++; if (swaps !== 4'd0) begin bad++; $display("FAIL zero_swaps got=%0d want=0", swaps); end
    start_idx = 4'd6;
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0 || cmp_valid !== 1'b0) begin
      bad++; $display("FAIL zero_no_restart got=%b/%b/%b want=0/0/0", busy, done, cmp_valid);
    end
    start = 1'b0; start_idx = 4'd0; cmp_ready = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid();
    logic hit = 1'b0;
    start = 1'b1; start_idx = 4'd10; cmp_ready = 1'b1; cmp_swap = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (cmp_idx == 4'd7 && cmp_valid) begin hit = 1'b1; break; end
      tick();
    end
    total++; if (hit !== 1'b1 || swaps !== 4'd3) begin bad++; $display("FAIL rstmid_pre got=%b/%0d want=1/3", hit, swaps); end
    rst = 1'b1;
    tick();
    rst = 1'b0; cmp_swap = 1'b0; cmp_ready = 1'b0;
    total++; if (busy !== 1'b0 || cmp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl got=%b/%b want=0/0", busy, cmp_valid); end
    total++; if (cmp_idx !== 4'd0 || swaps !== 4'd0) begin bad++; $display("FAIL rstmid_data got=%0d/%0d want=0/0", cmp_idx, swaps); end
    total++; if (tc !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL rstmid_tc_done got=%b/%b want=1/0", tc, done); end
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_after got=%b/%b want=0/0", done, busy); end
  endtask

  task automatic test_back_to_back();
    int e;
    int exp_sw = 0;
    int done_n = 0;
    int k = 0;
    exp_idx_q.delete();
    exp_idx_q.push_back(3); exp_idx_q.push_back(2); exp_idx_q.push_back(1);
    start = 1'b1; start_idx = 4'd3; cmp_ready = 1'b1; cmp_swap = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (done) begin
        done_n++;
        if (done_n == 1) begin
          // Start raised during DONE must wait for IDLE before it takes.
          start = 1'b1; start_idx = 4'd2;
          exp_idx_q.push_back(2); exp_idx_q.push_back(1);
          exp_sw = 0;
          tick();
          total++; if (busy !== 1'b0 || cmp_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b/%b want=0/0", busy, cmp_valid); end
          tick();
          start = 1'b0;
          total++; if (cmp_idx !== 4'd2 || cmp_valid !== 1'b1) begin bad++; $display("FAIL b2b_restart got=%0d/%b want=2/1", cmp_idx, cmp_valid); end
          continue;
        end else begin
          total++; if (swaps !== W'(exp_sw)) begin bad++; $display("FAIL b2b_swaps got=%0d want=%0d", swaps, exp_sw); end
          break;
        end
      end
      cmp_swap = (k % 2 == 0);
      if (cmp_valid && cmp_ready) begin
        k++;
        if (cmp_swap) exp_sw++;
        if (exp_idx_q.size() == 0) begin
          total++; bad++; $display("FAIL b2b_extra_hs got=%0d want=none", cmp_idx);
        end else begin
          e = exp_idx_q.pop_front();
          total++; if (cmp_idx !== W'(e)) begin bad++; $display("FAIL b2b_idx got=%0d want=%0d", cmp_idx, e); end
        end
      end
      tick();
    end
    total++; if (done_n != 2 || exp_idx_q.size() != 0) begin
      bad++; $display("FAIL b2b_complete got=%0d/%0d want=2/0", done_n, exp_idx_q.size());
    end
    cmp_swap = 1'b0; cmp_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_stall();
    test_saturate();
    test_abort();
    test_zero_start();
    test_rst_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
